// File: rtl/aes_seq_monitor.sv
// Plaintext-bus sequence monitor: flags and counts each occurrence of a programmed DEPTH-word
// sequence. Define SEQ_MON_MASK_EN to build per-stage compare masks.
module aes_seq_monitor #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ONESHOT = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arm,
    input  logic              i_clr,
    input  logic              i_cfg_we,
    input  logic              i_cfg_sel,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [WIDTH-1:0]  i_cfg_data,
    input  logic              i_in_valid,
    input  logic [WIDTH-1:0]  i_in_data,
    output logic              o_armed,
    output logic [ADDR_W-1:0] o_stage,
    output logic              o_hit,
    output logic [CNT_W-1:0]  o_hit_count
);

    typedef enum logic [1:0] {StIdle, StTrack, StDone} state_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_stage;
    logic                r_hit;
    logic [CNT_W-1:0]    r_hit_count;
    logic [WIDTH-1:0]    r_pat [DEPTH];

    logic [DEPTH-1:0]    w_match;
    logic                w_match_cur;
    logic                w_last;
    logic                w_beat;
    logic                w_hit;
    logic                w_cfg_ok;

    // Configuration is frozen while monitoring so a live sequence cannot be corrupted.
    assign w_cfg_ok = i_cfg_we && (r_state == StIdle) && (32'(i_cfg_addr) < DEPTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pat[i] <= '0;
        end else if (w_cfg_ok && !i_cfg_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_cfg_addr == ADDR_W'(i)) r_pat[i] <= i_cfg_data;
            end
        end
    end

`ifdef SEQ_MON_MASK_EN
    logic [WIDTH-1:0] r_mask [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mask[i] <= '1;
        end else if (w_cfg_ok && i_cfg_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_cfg_addr == ADDR_W'(i)) r_mask[i] <= i_cfg_data;
            end
        end
    end

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = (((i_in_data ^ r_pat[i]) & r_mask[i]) == '0);
        end
    end
`else
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = (i_in_data == r_pat[i]);
        end
    end
`endif

    always_comb begin
        w_match_cur = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_stage == ADDR_W'(i)) w_match_cur = w_match[i];
        end
    end

    assign w_last = (r_stage == ADDR_W'(DEPTH - 1));
    assign w_beat = (r_state == StTrack) && i_arm && i_in_valid;
    assign w_hit  = w_beat && w_last && w_match_cur;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_stage     <= '0;
            r_hit       <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_arm) r_state <= StTrack;
                end
                StTrack: begin
                    if (!i_arm) begin
                        r_state <= StIdle;
                        r_stage <= '0;
                    end else if (i_in_valid) begin
                        if (w_match_cur) begin
                            if (w_last) begin
                                r_stage <= '0;
                                r_hit   <= 1'b1;
                                if (ONESHOT != 0) r_state <= StDone;
                            end else begin
                                r_stage <= r_stage + 1'b1;
                            end
                        end else begin
                            // Only word 0 is re-checked on a break; deeper overlap is not tracked.
                            r_stage <= w_match[0] ? ADDR_W'(1) : '0;
                        end
                    end
                end
                StDone: begin
                    if (!i_arm) begin
                        r_state <= StIdle;
                        r_stage <= '0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_stage <= '0;
                end
            endcase

            if (i_clr) begin
                r_hit_count <= '0;
            end else if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
        end
    end

    assign o_armed     = (r_state != StIdle);
    assign o_stage     = r_stage;
    assign o_hit       = r_hit;
    assign o_hit_count = r_hit_count;

endmodule
